id_issue_sb: RTL and testbench

- Parametrised successor to the decode stage.
- Sits between fetch and execute. Holds the integer register file and a per-register scoreboard of outstanding writes.
- Issues one instruction per cycle over valid/ready handshakes, with operands already read.
- Stalls on read-after-write hazards until writeback retires the producer; writeback retires writes on a dedicated port.

---
 rtl/id_issue_sb.sv | 191 +++++++++++++++++++
 tb/tb_id_issue_sb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_sb.sv
// Decode/issue stage: register file, per-register write scoreboard and a single issue slot.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle writeback data to a source whose only pending write is retiring.
module id_issue_sb #(
    parameter int ADDR_W    = 32,
    parameter int INSTR_W   = 32,
    parameter int WORD_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int SB_CNT_W  = 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 clr,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [ADDR_W-1:0]    i_pc,
    input  logic [INSTR_W-1:0]   i_instr,
    input  logic                 i_uses_a,
    input  logic                 i_uses_b,
    input  logic                 i_dest_en,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ADDR_W-1:0]    o_pc,
    output logic [INSTR_W-1:0]   o_instr,
    output logic [WORD_W-1:0]    o_data_a,
    output logic [WORD_W-1:0]    o_data_b,
    output logic [REG_IDX_W-1:0] o_dest_reg,
    output logic                 o_dest_en,
    input  logic                 i_wb_en,
    input  logic [REG_IDX_W-1:0] i_wb_reg,
    input  logic [WORD_W-1:0]    i_wb_data,
    output logic                 o_raw_stall,
    output logic                 o_sb_err
);

    localparam int                  NUM_REGS = 2 ** REG_IDX_W;
    localparam logic [SB_CNT_W-1:0] SB_MAX   = '1;
    localparam logic [SB_CNT_W-1:0] SB_ONE   = SB_CNT_W'(1);

    logic [WORD_W-1:0]    rf       [NUM_REGS];
    logic [SB_CNT_W-1:0]  pend     [NUM_REGS];
    logic [SB_CNT_W-1:0]  pend_nxt [NUM_REGS];
    logic                 sb_err_set;

    logic                 vld_p1;
    logic [ADDR_W-1:0]    pc_p1;
    logic [INSTR_W-1:0]   instr_p1;
    logic [WORD_W-1:0]    data_a_p1;
    logic [WORD_W-1:0]    data_b_p1;
    logic [REG_IDX_W-1:0] dest_reg_p1;
    logic                 dest_en_p1;
    logic                 sb_err_q;

    logic [REG_IDX_W-1:0] rs_a_p0;
    logic [REG_IDX_W-1:0] rs_b_p0;
    logic [REG_IDX_W-1:0] rd_p0;
    logic                 dest_en_p0;
    logic                 fwd_a_p0;
    logic                 fwd_b_p0;
    logic                 hazard_a_p0;
    logic                 hazard_b_p0;
    logic                 hazard_d_p0;
    logic                 hazard_p0;
    logic                 accept_p0;
    logic [WORD_W-1:0]    data_a_p0;
    logic [WORD_W-1:0]    data_b_p0;

    // Counter step: sums one reservation and up to two retires; an underflow clamps to 0 and flags an error.
    function automatic logic [SB_CNT_W:0] sb_step(input logic [SB_CNT_W-1:0] cnt,
                                                  input logic inc,
                                                  input logic dec_wb,
                                                  input logic dec_clr);
        logic signed [SB_CNT_W+1:0] sum;
        sum = $signed({2'b00, cnt})
            + $signed({{(SB_CNT_W+1){1'b0}}, inc})
            - $signed({{(SB_CNT_W+1){1'b0}}, dec_wb})
            - $signed({{(SB_CNT_W+1){1'b0}}, dec_clr});
        if (sum < 0)
            sb_step = {1'b1, {SB_CNT_W{1'b0}}};
        else if (sum > $signed({2'b00, SB_MAX}))
            sb_step = {1'b0, SB_MAX};
        else
            sb_step = {1'b0, sum[SB_CNT_W-1:0]};
    endfunction

    // Operand select: unused sources and x0 read as 0; a forwarded source takes the writeback bus.
    function automatic logic [WORD_W-1:0] read_src(input logic uses,
                                                   input logic [REG_IDX_W-1:0] idx,
                                                   input logic fwd,
                                                   input logic [WORD_W-1:0] wb_data,
                                                   input logic [WORD_W-1:0] rf_val);
        if (!uses || idx == '0)
            read_src = '0;
        else if (fwd)
            read_src = wb_data;
        else
            read_src = rf_val;
    endfunction

    // Stage p0: decode, hazard detection, operand read
    assign rs_a_p0    = i_instr[19:15];
    assign rs_b_p0    = i_instr[24:20];
    assign rd_p0      = i_instr[11:7];
    assign dest_en_p0 = i_dest_en && (rd_p0 != '0);

`ifdef ID_WB_BYPASS_EN
    assign fwd_a_p0 = i_wb_en && (i_wb_reg == rs_a_p0) && (pend[rs_a_p0] == SB_ONE);
    assign fwd_b_p0 = i_wb_en && (i_wb_reg == rs_b_p0) && (pend[rs_b_p0] == SB_ONE);
`else
    assign fwd_a_p0 = 1'b0;
    assign fwd_b_p0 = 1'b0;
`endif

    assign hazard_a_p0 = i_uses_a && (rs_a_p0 != '0) && (pend[rs_a_p0] != '0) && !fwd_a_p0;
    assign hazard_b_p0 = i_uses_b && (rs_b_p0 != '0) && (pend[rs_b_p0] != '0) && !fwd_b_p0;
    assign hazard_d_p0 = dest_en_p0 && (pend[rd_p0] == SB_MAX);
    assign hazard_p0   = hazard_a_p0 || hazard_b_p0 || hazard_d_p0;

    assign o_ready     = (!vld_p1 || i_ready) && !hazard_p0 && !clr;
    assign o_raw_stall = i_valid && hazard_p0;
    assign accept_p0   = i_valid && o_ready;

    assign data_a_p0 = read_src(i_uses_a, rs_a_p0, fwd_a_p0, i_wb_data, rf[rs_a_p0]);
    assign data_b_p0 = read_src(i_uses_b, rs_b_p0, fwd_b_p0, i_wb_data, rf[rs_b_p0]);

    always_comb begin
        sb_err_set = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [SB_CNT_W:0] step;
            logic              inc;
            logic              dec_wb;
            logic              dec_clr;
            inc     = accept_p0 && dest_en_p0 && (rd_p0 == REG_IDX_W'(r));
            dec_wb  = i_wb_en && (i_wb_reg == REG_IDX_W'(r)) && (r != 0);
            dec_clr = clr && vld_p1 && dest_en_p1 && (dest_reg_p1 == REG_IDX_W'(r));
            step    = sb_step(pend[r], inc, dec_wb, dec_clr);
            pend_nxt[r] = (r == 0) ? '0 : step[SB_CNT_W-1:0];
            if (step[SB_CNT_W])
                sb_err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                rf[r]   <= '0;
                pend[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                pend[r] <= pend_nxt[r];
            if (i_wb_en && i_wb_reg != '0)
                rf[i_wb_reg] <= i_wb_data;
            if (sb_err_set)
                sb_err_q <= 1'b1;
        end
    end

    // Stage p1: issue slot towards execute
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            instr_p1    <= '0;
            data_a_p1   <= '0;
            data_b_p1   <= '0;
            dest_reg_p1 <= '0;
            dest_en_p1  <= 1'b0;
        end else if (accept_p0) begin
            vld_p1      <= 1'b1;
            pc_p1       <= i_pc;
            instr_p1    <= i_instr;
            data_a_p1   <= data_a_p0;
            data_b_p1   <= data_b_p0;
            dest_reg_p1 <= rd_p0;
            dest_en_p1  <= dest_en_p0;
        end else if (clr || i_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign o_valid    = vld_p1;
    assign o_pc       = pc_p1;
    assign o_instr    = instr_p1;
    assign o_data_a   = data_a_p1;
    assign o_data_b   = data_b_p1;
    assign o_dest_reg = dest_reg_p1;
    assign o_dest_en  = dest_en_p1;
    assign o_sb_err   = sb_err_q;

endmodule

// File: tb/tb_id_issue_sb.sv
// Directed bench for id_issue_sb: issue, RAW stall/release, backpressure, saturation, clr and scoreboard errors.
module tb_id_issue_sb;

    logic        clk;
    logic        aresetn;
    logic        clr;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_uses_a;
    logic        i_uses_b;
    logic        i_dest_en;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic [31:0] o_data_a;
    logic [31:0] o_data_b;
    logic [4:0]  o_dest_reg;
    logic        o_dest_en;
    logic        i_wb_en;
    logic [4:0]  i_wb_reg;
    logic [31:0] i_wb_data;
    logic        o_raw_stall;
    logic        o_sb_err;

    int checks;
    int errors;

    id_issue_sb dut (
        .clk(clk), .aresetn(aresetn), .clr(clr),
        .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc), .i_instr(i_instr),
        .i_uses_a(i_uses_a), .i_uses_b(i_uses_b), .i_dest_en(i_dest_en),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instr(o_instr),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_dest_reg(o_dest_reg),
        .o_dest_en(o_dest_en), .i_wb_en(i_wb_en), .i_wb_reg(i_wb_reg),
        .i_wb_data(i_wb_data), .o_raw_stall(o_raw_stall), .o_sb_err(o_sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        mk = {7'h00, rs2, rs1, 3'b000, rd, 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic ua, input logic ub, input logic de);
        i_valid   = 1'b1;
        i_pc      = pc;
        i_instr   = instr;
        i_uses_a  = ua;
        i_uses_b  = ub;
        i_dest_en = de;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        aresetn   = 1'b0;
        clr       = 1'b0;
        i_valid   = 1'b0;
        i_pc      = '0;
        i_instr   = '0;
        i_uses_a  = 1'b0;
        i_uses_b  = 1'b0;
        i_dest_en = 1'b0;
        i_ready   = 1'b1;
        i_wb_en   = 1'b0;
        i_wb_reg  = '0;
        i_wb_data = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_instr", o_instr, 0);
        chk("rst_data_a", o_data_a, 0);
        chk("rst_dest_en", o_dest_en, 0);
        chk("rst_sb_err", o_sb_err, 0);
        chk("rst_ready", o_ready, 1);
        aresetn = 1'b1;
        cyc();

        // addi x5: issues one cycle later, reserves x5
        drive(32'h100, mk(5'd5, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
        #1;
        chk("x5_ready", o_ready, 1);
        cyc();
        chk("x5_valid", o_valid, 1);
        chk("x5_pc", o_pc, 32'h100);
        chk("x5_dest_reg", o_dest_reg, 5);
        chk("x5_dest_en", o_dest_en, 1);
        chk("pend5_1", dut.pend[5], 1);

        // consumer of x5 stalls on RAW
        drive(32'h104, mk(5'd6, 5'd5, 5'd0), 1'b1, 1'b0, 1'b1);
        #1;
        chk("raw_stall", o_raw_stall, 1);
        chk("raw_ready", o_ready, 0);
        cyc();
        chk("raw_drained", o_valid, 0);
        i_wb_en   = 1'b1;
        i_wb_reg  = 5'd5;
        i_wb_data = 32'h1234;
        #1;
`ifdef ID_WB_BYPASS_EN
        chk("byp_stall", o_raw_stall, 0);
        chk("byp_ready", o_ready, 1);
        cyc();
        i_wb_en = 1'b0;
`else
        chk("nobyp_stall", o_raw_stall, 1);
        cyc();
        i_wb_en = 1'b0;
        #1;
        chk("nobyp_release", o_raw_stall, 0);
        chk("nobyp_valid0", o_valid, 0);
        cyc();
`endif
        chk("raw_issue_valid", o_valid, 1);
        chk("raw_issue_pc", o_pc, 32'h104);
        chk("raw_issue_data_a", o_data_a, 32'h1234);
        chk("pend5_0", dut.pend[5], 0);

        // backpressure: slot holds for 5 cycles, then next input goes in
        i_ready = 1'b0;
        drive(32'h108, mk(5'd8, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
        #1;
        chk("bp_ready", o_ready, 0);
        chk("bp_no_raw", o_raw_stall, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_hold_pc", o_pc, 32'h104);
            chk("bp_hold_data", o_data_a, 32'h1234);
        end
        chk("bp_hold_instr", o_instr, mk(5'd6, 5'd5, 5'd0));
        chk("bp_hold_valid", o_valid, 1);
        i_ready = 1'b1;
        #1;
        chk("bp_release_ready", o_ready, 1);
        cyc();
        chk("bp_next_pc", o_pc, 32'h108);
        chk("bp_next_rd", o_dest_reg, 8);

        // three writers of x7 saturate its counter; a fourth stalls until a retire
        for (int k = 0; k < 3; k++) begin
            drive(32'h200 + 32'(4 * k), mk(5'd7, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
            cyc();
        end
        chk("pend7_3", dut.pend[7], 3);
        drive(32'h20C, mk(5'd7, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
        #1;
        chk("sat_stall", o_raw_stall, 1);
        chk("sat_ready", o_ready, 0);
        cyc();
        chk("sat_stall2", o_raw_stall, 1);
        i_wb_en   = 1'b1;
        i_wb_reg  = 5'd7;
        i_wb_data = 32'h77;
        #1;
        chk("sat_stall_wb", o_raw_stall, 1);
        cyc();
        i_wb_en = 1'b0;
        #1;
        chk("sat_release", o_ready, 1);
        chk("pend7_2", dut.pend[7], 2);
        cyc();
        chk("sat_issue_pc", o_pc, 32'h20C);
        chk("pend7_back3", dut.pend[7], 3);

        // simultaneous reserve and retire of x9, then clr drops the held reservation
        drive(32'h300, mk(5'd9, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
        cyc();
        chk("pend9_1", dut.pend[9], 1);
        drive(32'h304, mk(5'd9, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
        i_wb_en   = 1'b1;
        i_wb_reg  = 5'd9;
        i_wb_data = 32'h99;
        cyc();
        i_wb_en = 1'b0;
        chk("pend9_same", dut.pend[9], 1);
        chk("x9_slot_pc", o_pc, 32'h304);
        i_valid = 1'b0;
        clr     = 1'b1;
        #1;
        chk("clr_ready", o_ready, 0);
        cyc();
        clr = 1'b0;
        chk("clr_pend9", dut.pend[9], 0);
        chk("clr_valid", o_valid, 0);
        chk("clr_no_err", o_sb_err, 0);
        chk("clr_pend7", dut.pend[7], 3);

        // retire of an idle register flags a sticky error
        i_wb_en   = 1'b1;
        i_wb_reg  = 5'd3;
        i_wb_data = 32'h33;
        cyc();
        i_wb_en = 1'b0;
        chk("err_set", o_sb_err, 1);
        chk("pend3_0", dut.pend[3], 0);
        cyc();
        cyc();
        chk("err_sticky", o_sb_err, 1);

        // writeback to x0 is ignored
        i_wb_en   = 1'b1;
        i_wb_reg  = 5'd0;
        i_wb_data = 32'hFFFF;
        cyc();
        i_wb_en = 1'b0;
        chk("pend0_0", dut.pend[0], 0);

        // unused source reads 0, used source sees written x3, rd=0 clears dest_en
        drive(32'h400, mk(5'd0, 5'd3, 5'd3), 1'b0, 1'b1, 1'b1);
        cyc();
        chk("unused_a", o_data_a, 0);
        chk("x3_b", o_data_b, 32'h33);
        chk("rd0_dest_en", o_dest_en, 0);
        drive(32'h404, mk(5'd0, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0);
        cyc();
        chk("x0_reads0", o_data_a, 0);
        chk("x0_pc", o_pc, 32'h404);
        chk("pend0_still0", dut.pend[0], 0);

        // asynchronous reset mid-operation
        drive(32'h500, mk(5'd10, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
        cyc();
        #2;
        aresetn = 1'b0;
        #1;
        chk("areset_valid", o_valid, 0);
        chk("areset_pc", o_pc, 0);
        chk("areset_pend7", dut.pend[7], 0);
        chk("areset_err", o_sb_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
